// File: rtl/music_pkg.sv
// Shared note codes, half-period table and player state encoding
// for the multi-note tone player.
package music_pkg;

    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [2:0] NOTE_G    = 3'd1;
    localparam logic [2:0] NOTE_A    = 3'd2;
    localparam logic [2:0] NOTE_B    = 3'd3;
    localparam logic [2:0] NOTE_C    = 3'd4;
    localparam logic [2:0] NOTE_D    = 3'd5;
    localparam logic [2:0] NOTE_E    = 3'd6;
    localparam logic [2:0] NOTE_F    = 3'd7;

    localparam logic [4:0] HP_G    = 5'd20;
    localparam logic [4:0] HP_A    = 5'd18;
    localparam logic [4:0] HP_B    = 5'd16;
    localparam logic [4:0] HP_C    = 5'd15;
    localparam logic [4:0] HP_D    = 5'd13;
    localparam logic [4:0] HP_E    = 5'd12;
    localparam logic [4:0] HP_F    = 5'd11;
    // Rest still paces the half counter; the toggle is suppressed
    localparam logic [4:0] HP_REST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } player_state_t;

    function automatic logic [4:0] hp_of(input logic [2:0] note);
        logic [4:0] hp;
        hp = HP_REST;
        case (note)
            NOTE_G:  hp = HP_G;
            NOTE_A:  hp = HP_A;
            NOTE_B:  hp = HP_B;
            NOTE_C:  hp = HP_C;
            NOTE_D:  hp = HP_D;
            NOTE_E:  hp = HP_E;
            NOTE_F:  hp = HP_F;
            default: hp = HP_REST;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/note_tone_gen.sv
// Square-wave generator: tick prescaler, half-period counter
// and the output toggle flop.
module note_tone_gen
    import music_pkg::*;
#(
    parameter logic [15:0] TICK_DIV = 16'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [2:0] note,
    output logic       audio_out
);

    logic [15:0] tick_cnt;
    logic [4:0]  half_cnt;
    logic [4:0]  hp;
    logic        tick;
    logic        half_end;

    assign hp       = hp_of(note);
    assign tick     = (tick_cnt == TICK_DIV - 16'd1);
    assign half_end = (half_cnt == hp - 5'd1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick_cnt  <= '0;
            half_cnt  <= '0;
            audio_out <= 1'b0;
        end else if (en) begin
            if (tick) begin
                tick_cnt <= '0;
                if (half_end) begin
                    half_cnt <= '0;
                    if (note != NOTE_REST)
                        audio_out <= ~audio_out;
                end else begin
                    half_cnt <= half_cnt + 5'd1;
                end
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/multi_note_player.sv
// Note player: latches a note code, plays it for DUR_CYCLES,
// then pulses play_done for one cycle.
module multi_note_player
    import music_pkg::*;
#(
    parameter logic [23:0] DUR_CYCLES = 24'd6_250_000,
    parameter logic [15:0] TICK_DIV   = 16'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] play_note,
    input  logic       play_load,
    output logic       play_done,
    output logic       busy,
    output logic       audio_out
);

    player_state_t state;
    logic [23:0]   dur_cnt;
    logic [2:0]    note_q;
    logic          tone;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dur_cnt <= '0;
            note_q  <= NOTE_REST;
        end else if (play_load) begin
            state   <= PLAY;
            dur_cnt <= DUR_CYCLES - 24'd1;
            note_q  <= play_note;
        end else begin
            case (state)
                PLAY: begin
                    if (dur_cnt == 24'd0)
                        state <= DONE;
                    else
                        dur_cnt <= dur_cnt - 24'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == PLAY);
    assign play_done = (state == DONE);

    note_tone_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tone (
        .clk      (clk),
        .rst      (rst),
        .clear    (play_load),
        .en       (busy && !play_load),
        .note     (note_q),
        .audio_out(tone)
    );

    // Tone flop may toggle on the final PLAY edge; keep it silent outside PLAY
    assign audio_out = tone & busy;

endmodule

// File: tb/tb_multi_note_player.sv
// Directed bench for multi_note_player: three parameterisations
// checked every cycle against a timeline model plus literal points.
module tb_multi_note_player;

    localparam int DURS[3] = '{100, 200, 1};
    localparam int TDS[3]  = '{1, 3, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] note_in;
    logic [2:0] load_v;
    logic [2:0] done_v;
    logic [2:0] busy_v;
    logic [2:0] aud_v;

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;

    bit       act[3];
    int       jj[3];
    logic [2:0] mnote[3];

    always #5 clk = ~clk;

    multi_note_player #(.DUR_CYCLES(24'd100), .TICK_DIV(16'd1)) u_a (
        .clk(clk), .rst(rst), .play_note(note_in), .play_load(load_v[0]),
        .play_done(done_v[0]), .busy(busy_v[0]), .audio_out(aud_v[0])
    );
    multi_note_player #(.DUR_CYCLES(24'd200), .TICK_DIV(16'd3)) u_b (
        .clk(clk), .rst(rst), .play_note(note_in), .play_load(load_v[1]),
        .play_done(done_v[1]), .busy(busy_v[1]), .audio_out(aud_v[1])
    );
    multi_note_player #(.DUR_CYCLES(24'd1), .TICK_DIV(16'd1)) u_c (
        .clk(clk), .rst(rst), .play_note(note_in), .play_load(load_v[2]),
        .play_done(done_v[2]), .busy(busy_v[2]), .audio_out(aud_v[2])
    );

    function automatic int half_period(input logic [2:0] n);
        case (n)
            3'd1: return 20;
            3'd2: return 18;
            3'd3: return 16;
            3'd4: return 15;
            3'd5: return 13;
            3'd6: return 12;
            3'd7: return 11;
            default: return 1;
        endcase
    endfunction

    // Model: j counts edges since the accepted load
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                act[i] = 1'b0;
            end else if (load_v[i]) begin
                act[i] = 1'b1;
                jj[i] = 0;
                mnote[i] = note_in;
            end else if (act[i] && jj[i] <= DURS[i]) begin
                jj[i] = jj[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic eb, ed, ea;
                eb = 1'b0; ed = 1'b0; ea = 1'b0;
                if (act[i] && jj[i] < DURS[i]) begin
                    eb = 1'b1;
                    if (mnote[i] != 3'd0)
                        ea = ((jj[i] / (TDS[i] * half_period(mnote[i]))) % 2) == 1;
                end else if (act[i] && jj[i] == DURS[i]) begin
                    ed = 1'b1;
                end
                tests++;
                if ({busy_v[i], done_v[i], aud_v[i]} !== {eb, ed, ea}) begin
                    fails++;
                    $display("FAIL model[%0d] t=%0t busy/done/audio got %b%b%b expected %b%b%b",
                             i, $time, busy_v[i], done_v[i], aud_v[i], eb, ed, ea);
                end
            end
        end
    end

    task automatic lit(input string nm, input int act_v, input int exp_v);
        tests++;
        if (act_v != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int i, input logic [2:0] n);
        note_in = n;
        load_v[i] = 1'b1;
        @(negedge clk);
        load_v[i] = 1'b0;
    endtask

    initial begin
        int dcnt;
        rst = 1'b1;
        load_v = '0;
        note_in = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lit("reset_state", {done_v, busy_v, aud_v}, 0);

        // G on A: toggles at t+21, t+41; busy t+1..t+100; done t+101
        load(0, 3'd1);
        lit("g_busy_first", busy_v[0], 1);
        cyc(19); lit("g_pre_rise", aud_v[0], 0);
        cyc(1);  lit("g_rise_t21", aud_v[0], 1);
        cyc(20); lit("g_fall_t41", aud_v[0], 0);
        cyc(59); lit("g_busy_last", busy_v[0], 1);
        cyc(1);  lit("g_done_t101", done_v[0], 1);
        cyc(1);  lit("g_done_once", done_v[0], 0);

        // F on B, TICK_DIV=3: rise t+34, fall t+67, rise t+100
        load(1, 3'd7);
        cyc(32); lit("f_pre_rise", aud_v[1], 0);
        cyc(1);  lit("f_rise_t34", aud_v[1], 1);
        cyc(33); lit("f_fall_t67", aud_v[1], 0);
        cyc(33); lit("f_rise_t100", aud_v[1], 1);
        cyc(102);

        // REST on B: silent, done after DUR
        load(1, 3'd0);
        cyc(200); lit("rest_done", done_v[1], 1);
        cyc(2);

        // Reload A with C mid-note
        load(0, 3'd2);
        cyc(29); lit("a_high_before_reload", aud_v[0], 1);
        load(0, 3'd4);
        lit("reload_audio_low", aud_v[0], 0);
        lit("reload_no_done", done_v[0], 0);
        cyc(15); lit("c_rise", aud_v[0], 1);
        cyc(15); lit("c_fall", aud_v[0], 0);
        cyc(70); lit("c_done_t131", done_v[0], 1);
        cyc(2);

        // DONE->PLAY, then DONE->IDLE->PLAY
        load(0, 3'd5);
        cyc(100); lit("b2b_done", done_v[0], 1);
        load(0, 3'd6);
        lit("b2b_busy", busy_v[0], 1);
        lit("b2b_no_extra_done", done_v[0], 0);
        cyc(100); lit("b2b_done2", done_v[0], 1);
        cyc(1);  lit("idle_one_cycle", busy_v[0] | done_v[0], 0);
        load(0, 3'd7);
        lit("ctrl_load_busy", busy_v[0], 1);
        cyc(102);

        // DUR_CYCLES=1 on C: seven notes -> seven dones
        dcnt = 0;
        for (int n = 1; n <= 7; n++) begin
            load(2, 3'(n));
            if (busy_v[2]) dcnt++;
            @(negedge clk); if (done_v[2]) dcnt++;
            @(negedge clk); if (done_v[2]) dcnt++;
        end
        lit("seven_busy_plus_done", dcnt, 14);

        // Reset mid-PLAY with a load during reset
        load(0, 3'd3);
        cyc(10);
        rst = 1'b1;
        load_v = 3'b111;
        cyc(2);
        rst = 1'b0;
        load_v = '0;
        @(negedge clk);
        lit("reset_mid_play", {done_v, busy_v, aud_v}, 0);
        cyc(5);
        lit("reset_no_done", done_v[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
